timer_dev: RTL and testbench
============================

// Module: timer_dev
// PURPOSE
//  Programmable down-counting timer on the peripheral bus. It raises one hardware
//  interrupt line that drives one bit of the coprocessor-0 HWInt[7:2] input.
//  Software programs CTRL and PRESET through load/store to the device window.
//  One-shot mode (0) and auto-reload mode (1) are supported.
// PARAMETERS
//  CNT_W   32   width of PRESET/COUNT; bus data is 32b, upper bits read 0 if CNT_W<32
// PORTS
//  clk    in   1      clock, rising edge
//  rst    in   1      asynchronous, active-high reset
//  addr   in   [3:2]  word select: 0=CTRL 1=PRESET 2=COUNT 3=reserved
//  we     in   1      write strobe, sampled on clk rise
//  din    in   32     write data
//  dout   out  32     read data, combinational from addr
//  irq    out  1      interrupt request to CP0 HWInt bit
// BEHAVIOUR
//  Registers:
//   - CTRL[3:0] = {IM, MODE[1:0], EN}; upper bits read 0.
//   - PRESET is RW. COUNT is RO; writes to it are ignored.
//  Reset (async): CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_pend=0, so irq=0.
//  Bus writes:
//   - we && addr==0: CTRL <= din[3:0]; also clears irq_pend.
//   - we && addr==1: PRESET <= din[CNT_W-1:0]; also clears irq_pend; COUNT untouched.
//  dout mapping: addr 0 -> {28'b0,CTRL}; 1 -> PRESET; 2 -> COUNT; 3 -> 32'b0.
//  irq = irq_pend & IM (combinational). Clearing IM masks irq but keeps irq_pend.
//  FSM transitions:
//   - IDLE : EN=1 -> LOAD.
//   - LOAD : COUNT <= PRESET -> CNT.
//   - CNT  : EN=0 -> IDLE (COUNT frozen).
//            else COUNT<=1 -> COUNT<=0, irq_pend<=1, -> INT.
//            else COUNT <= COUNT-1.
//   - INT  : MODE==0 -> EN<=0, -> IDLE; irq_pend held until a CTRL/PRESET write.
//            MODE==1 -> irq_pend<=0, -> IDLE (1-cycle pulse); EN stays 1, so it reloads.
//            MODE==2,3 -> treated as MODE 0.
//  Latency: an EN write at edge E0 gives IDLE@E1, LOAD@E2 (COUNT=P), INT entered at E0+P+2.
//  Mode-1 period is P+3 cycles between INT entries.
//  PRESET=0 behaves as PRESET=1: INT is entered one edge after LOAD. COUNT never wraps below 0.
//  Simultaneous events:
//   - A bus CTRL write in the same cycle as the INT auto-clear of EN: the bus value wins.
//   - A CTRL/PRESET write in the same cycle as irq_pend set: the clear wins.
//   - A PRESET write during CNT affects only the next LOAD.
//  Reset mid-count: immediate return to the reset values above, irq drops asynchronously.
// TESTING
//  1. Reset: assert rst mid-count -> irq=0, dout@0/1/2 = 0 same cycle, state IDLE.
//  2. One-shot: PRESET=5, CTRL=4'b1001 @E0 -> irq rises after edge E0+7.
//     irq stays 1; CTRL reads 4'b1000; writing CTRL=0 drops irq next edge.
//  3. Auto-reload: PRESET=3, CTRL=4'b1011 -> irq 1-cycle pulses every 6 cycles.
//     COUNT sequence reads 3,2,1,0.
//  4. Mask: PRESET=2, CTRL=4'b0001 -> irq never rises.
//     Then write CTRL=4'b1000 -> irq stays 0 (the write clears pend).
//  5. Boundary: PRESET=0, EN=1 -> INT reached 3 edges after the EN write; COUNT reads 0, no wrap.
//  6. Stop/collision: clear EN mid-count -> COUNT frozen, no irq.
//     A CTRL write coincident with the INT edge -> the written CTRL value persists.

Source files
------------

// File: rtl/timer_dev.sv
// Programmable down-counting timer on the peripheral bus.
// Word-addressed window: 0=CTRL {IM, MODE[1:0], EN}, 1=PRESET, 2=COUNT (read-only), 3=reserved.
// The timer raises a maskable interrupt when COUNT reaches zero.
// One-shot mode stops the timer at that point. Auto-reload mode restarts it from PRESET.
module timer_dev #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:2]       addr,
    input  logic             we,
    input  logic [31:0]      din,
    output logic [31:0]      dout,
    output logic             irq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    state_t           state;
    logic [3:0]       ctrl;      // {IM, MODE[1:0], EN}
    logic [CNT_W-1:0] preset;
    logic [CNT_W-1:0] count;
    logic             irq_pend;

    logic ctrl_wr;
    logic preset_wr;

    assign ctrl_wr   = we && (addr == ADDR_CTRL);
    assign preset_wr = we && (addr == ADDR_PRESET);

    // Timer FSM plus the bus-visible registers it shares write access with.
    // Bus writes come after the FSM updates, so a bus write overrides the FSM in the same cycle.
    // This applies to the INT auto-clear of EN and to the set of irq_pend.
    // NOTE: non-blocking assignments in clocked logic: every register samples pre-edge
    // values, and the later assignment in program order wins when two target one register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            ctrl     <= 4'd0;
            preset   <= '0;
            count    <= '0;
            irq_pend <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ctrl[0]) begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    count <= preset;
                    state <= S_CNT;
                end
                S_CNT: begin
                    if (!ctrl[0]) begin
                        // Disabled mid-count: COUNT holds its value.
                        state <= S_IDLE;
                    end else if (count < CNT_W'(2)) begin
                        // A COUNT of 0 or 1 terminates here, so COUNT never wraps.
                        // This also makes PRESET=0 behave like PRESET=1.
                        count    <= '0;
                        irq_pend <= 1'b1;
                        state    <= S_INT;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                S_INT: begin
                    if (ctrl[2:1] == 2'd1) begin
                        // Auto-reload: one-cycle pulse. EN stays set, so IDLE reloads.
                        irq_pend <= 1'b0;
                    end else begin
                        // One-shot (MODE 0, 2, 3): stop and leave the interrupt pending.
                        ctrl[0] <= 1'b0;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (ctrl_wr) begin
                ctrl     <= din[3:0];
                irq_pend <= 1'b0;
            end
            if (preset_wr) begin
                preset   <= din[CNT_W-1:0];
                irq_pend <= 1'b0;
            end
        end
    end

    // Combinational read mux; unused upper bits and the reserved word read as zero.
    // NOTE: dout gets a default before the case so every path assigns it and no latch is inferred.
    always_comb begin
        dout = 32'd0;
        case (addr)
            ADDR_CTRL:   dout = {28'd0, ctrl};
            ADDR_PRESET: dout = 32'(preset);
            ADDR_COUNT:  dout = 32'(count);
            default:     dout = 32'd0;
        endcase
    end

    assign irq = irq_pend & ctrl[3];

endmodule

// File: tb/tb_timer_dev.sv
// Directed self-checking bench for timer_dev.
// A cycle-by-cycle vector table covers the one-shot run.
// Hand-written sequences cover auto-reload, masking, PRESET=0, stop, collisions and reset.
module tb_timer_dev;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    timer_dev #(.CNT_W(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .we   (we),
        .din  (din),
        .dout (dout),
        .irq  (irq)
    );

    // One bus cycle per vector: optional write on the edge, then a read and an irq check.
    typedef struct {
        logic        we;
        logic [1:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  raddr;
        logic [31:0] exp_dout;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a;
        din  = d;
        we   = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(name, dout, exp);
    endtask

    initial begin
        rst  = 1'b1;
        we   = 1'b0;
        addr = 2'd0;
        din  = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Reset state
        check("reset_irq", {31'd0, irq}, 32'd0);
        read_chk("reset_ctrl", 2'd0, 32'd0);
        read_chk("reset_preset", 2'd1, 32'd0);
        read_chk("reset_count", 2'd2, 32'd0);

        // One-shot with PRESET=5, CTRL=1001 written at E0.
        // INT is entered at E7, EN auto-clears at E8, and a CTRL=0 write drops irq.
        vecs[0]  = '{1'b1, 2'd1, 32'd5, 2'd1, 32'd5, 1'b0};   // PRESET=5
        vecs[1]  = '{1'b1, 2'd0, 32'h9, 2'd0, 32'h9, 1'b0};   // E0: CTRL=1001
        vecs[2]  = '{1'b0, 2'd0, 32'd0, 2'd2, 32'd0, 1'b0};   // E1: IDLE->LOAD
        vecs[3]  = '{1'b0, 2'd0, 32'd0, 2'd2, 32'd5, 1'b0};   // E2: COUNT=P
        vecs[4]  = '{1'b0, 2'd0, 32'd0, 2'd2, 32'd4, 1'b0};
        vecs[5]  = '{1'b0, 2'd0, 32'd0, 2'd2, 32'd3, 1'b0};
        vecs[6]  = '{1'b0, 2'd0, 32'd0, 2'd2, 32'd2, 1'b0};
        vecs[7]  = '{1'b0, 2'd0, 32'd0, 2'd2, 32'd1, 1'b0};
        vecs[8]  = '{1'b0, 2'd0, 32'd0, 2'd2, 32'd0, 1'b1};   // E7: INT
        vecs[9]  = '{1'b0, 2'd0, 32'd0, 2'd0, 32'h8, 1'b1};   // E8: EN cleared
        vecs[10] = '{1'b0, 2'd0, 32'd0, 2'd0, 32'h8, 1'b1};   // irq held
        vecs[11] = '{1'b1, 2'd0, 32'd0, 2'd0, 32'd0, 1'b0};   // CTRL=0 clears
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            we   = vecs[i].we;
            addr = vecs[i].waddr;
            din  = vecs[i].wdata;
            @(posedge clk);
            #1;
            we   = 1'b0;
            addr = vecs[i].raddr;
            #1;
            check($sformatf("oneshot_dout[%0d]", i), dout, vecs[i].exp_dout);
            check($sformatf("oneshot_irq[%0d]", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
        end

        // Auto-reload with PRESET=3: INT at E5, E11 and E17, each a single-cycle pulse.
        bus_write(2'd1, 32'd3);
        bus_write(2'd0, 32'hB);
        for (int k = 1; k <= 18; k++) begin
            logic        exp_irq;
            logic [31:0] exp_cnt;
            int          phase;
            tick();
            exp_irq = (k >= 5) && ((k - 5) % 6 == 0);
            phase   = (k - 2) % 6;
            exp_cnt = (k < 2) ? 32'd0 : ((phase <= 3) ? 32'(3 - phase) : 32'd0);
            check($sformatf("reload_irq[k=%0d]", k), {31'd0, irq}, {31'd0, exp_irq});
            read_chk($sformatf("reload_count[k=%0d]", k), 2'd2, exp_cnt);
        end
        bus_write(2'd0, 32'd0);
        repeat (3) tick();

        // Masked one-shot: irq_pend sets but irq stays low; unmasking via a CTRL write clears it.
        bus_write(2'd1, 32'd2);
        bus_write(2'd0, 32'h1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("mask_irq[k=%0d]", k), {31'd0, irq}, 32'd0);
        end
        read_chk("mask_ctrl_en_cleared", 2'd0, 32'd0);
        bus_write(2'd0, 32'h8);
        check("mask_unmask_irq", {31'd0, irq}, 32'd0);
        tick();
        check("mask_unmask_irq_later", {31'd0, irq}, 32'd0);

        // PRESET=0: INT is reached 3 edges after the EN write and COUNT stays at 0.
        bus_write(2'd1, 32'd0);
        bus_write(2'd0, 32'h9);
        tick();
        check("p0_irq_k1", {31'd0, irq}, 32'd0);
        tick();
        check("p0_irq_k2", {31'd0, irq}, 32'd0);
        read_chk("p0_count_k2", 2'd2, 32'd0);
        tick();
        check("p0_irq_k3", {31'd0, irq}, 32'd1);
        read_chk("p0_count_k3", 2'd2, 32'd0);
        tick();
        read_chk("p0_count_k4", 2'd2, 32'd0);
        read_chk("p0_ctrl_k4", 2'd0, 32'h8);
        bus_write(2'd0, 32'd0);
        check("p0_clear_irq", {31'd0, irq}, 32'd0);

        // Stop mid-count: clear EN at E5, then COUNT freezes at 7.
        // Writes to COUNT and reads of the reserved word have no effect.
        bus_write(2'd1, 32'd10);
        bus_write(2'd0, 32'h9);
        repeat (4) tick();
        read_chk("stop_count_k4", 2'd2, 32'd8);
        bus_write(2'd0, 32'h8);
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("stop_irq[%0d]", k), {31'd0, irq}, 32'd0);
            read_chk($sformatf("stop_count[%0d]", k), 2'd2, 32'd7);
        end
        bus_write(2'd2, 32'h55);
        read_chk("count_write_ignored", 2'd2, 32'd7);
        read_chk("reserved_reads_zero", 2'd3, 32'd0);

        // Collision: a CTRL write on the INT-exit edge (E5) wins over the auto-clear of EN.
        bus_write(2'd1, 32'd2);
        bus_write(2'd0, 32'h9);
        repeat (4) tick();
        check("coll_irq_at_int", {31'd0, irq}, 32'd1);
        bus_write(2'd0, 32'h9);
        read_chk("coll_ctrl_wins", 2'd0, 32'h9);
        check("coll_irq_cleared", {31'd0, irq}, 32'd0);
        repeat (2) tick();
        read_chk("coll_ctrl_persists", 2'd0, 32'h9);
        read_chk("coll_reloaded", 2'd2, 32'd2);
        bus_write(2'd0, 32'd0);
        repeat (3) tick();

        // Collision: a PRESET write on the edge that sets irq_pend leaves irq_pend clear.
        bus_write(2'd1, 32'd2);
        bus_write(2'd0, 32'h9);
        repeat (3) tick();
        bus_write(2'd1, 32'd2);
        check("pend_coll_irq", {31'd0, irq}, 32'd0);
        read_chk("pend_coll_count", 2'd2, 32'd0);
        tick();
        check("pend_coll_irq_next", {31'd0, irq}, 32'd0);
        read_chk("pend_coll_ctrl", 2'd0, 32'h8);

        // Reset mid-count: all registers read zero in the same cycle.
        bus_write(2'd1, 32'd20);
        bus_write(2'd0, 32'h9);
        repeat (5) tick();
        read_chk("midcnt_count", 2'd2, 32'd17);
        #1;
        rst = 1'b1;
        #1;
        check("rst_irq", {31'd0, irq}, 32'd0);
        read_chk("rst_ctrl", 2'd0, 32'd0);
        read_chk("rst_preset", 2'd1, 32'd0);
        read_chk("rst_count", 2'd2, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) tick();
        read_chk("rst_idle_count", 2'd2, 32'd0);

        // An asserted irq drops asynchronously with reset.
        bus_write(2'd1, 32'd2);
        bus_write(2'd0, 32'h9);
        repeat (4) tick();
        check("rst2_irq_before", {31'd0, irq}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("rst2_irq_after", {31'd0, irq}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("rst2_irq_released", {31'd0, irq}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
